// File: rtl/crossing_phase_controller.sv
// -----------------------------------------------------------------------------
// crossing_phase_controller
//
// Purpose: sequences a pedestrian crossing. Cars run green by default. A press
// on either kerb latches a wait request, which is served by one timed walk
// cycle. The cycle runs only after a minimum car-green interval, and all-red
// clearance phases separate the conflicting movements.
//
// Optional feature: define CROSSING_FLASH_EN to build the flashing-walk phase
// (PED_FLASH) between PED_WALK and ALL_RED_POST. Without it, PED_WALK goes
// straight to ALL_RED_POST, and encoding 4 is treated as an illegal state.
//
// Ports:
//   clk         system clock
//   rst         asynchronous, active-high reset
//   req_a       debounced single-cycle press pulse, kerb A
//   req_b       debounced single-cycle press pulse, kerb B
//   car_green   car green lamp
//   car_yellow  car yellow lamp
//   car_red     car red lamp
//   ped_walk    pedestrian walk lamp
//   ped_stop    pedestrian don't-walk lamp
//   wait_a      kerb A request latched indicator
//   wait_b      kerb B request latched indicator
//   phase       current state encoding (debug)
// -----------------------------------------------------------------------------
module crossing_phase_controller #(
  parameter int MIN_GREEN    = 500000000,
  parameter int YELLOW_TIME  = 150000000,
  parameter int ALL_RED_TIME = 50000000,
  parameter int WALK_TIME    = 350000000,
  parameter int FLASH_TIME   = 200000000,
  parameter int FLASH_PERIOD = 25000000,
  parameter int TIMER_W      = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic       req_b,
  output logic       car_green,
  output logic       car_yellow,
  output logic       car_red,
  output logic       ped_walk,
  output logic       ped_stop,
  output logic       wait_a,
  output logic       wait_b,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    CAR_GREEN    = 3'd0,
    CAR_YELLOW   = 3'd1,
    ALL_RED_PRE  = 3'd2,
    PED_WALK     = 3'd3,
    PED_FLASH    = 3'd4,
    ALL_RED_POST = 3'd5
  } state_t;

  // Last timer value of each timed state: a state of duration T exits when
  // the timer, cleared on entry, reaches T-1.
  localparam logic [TIMER_W-1:0] MIN_GREEN_LAST = TIMER_W'(MIN_GREEN - 1);
  localparam logic [TIMER_W-1:0] YELLOW_LAST    = TIMER_W'(YELLOW_TIME - 1);
  localparam logic [TIMER_W-1:0] ALL_RED_LAST   = TIMER_W'(ALL_RED_TIME - 1);
  localparam logic [TIMER_W-1:0] WALK_LAST      = TIMER_W'(WALK_TIME - 1);
`ifdef CROSSING_FLASH_EN
  localparam logic [TIMER_W-1:0] FLASH_LAST     = TIMER_W'(FLASH_TIME - 1);
  localparam logic [TIMER_W-1:0] BLINK_LAST     = TIMER_W'(FLASH_PERIOD - 1);
`endif

  localparam logic [TIMER_W-1:0] TIMER_ZERO = {TIMER_W{1'b0}};
  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);

  state_t             state_r;
  state_t             state_nxt;
  logic [TIMER_W-1:0] timer_r;
  logic [TIMER_W-1:0] timer_nxt;
  logic               wait_a_r;
  logic               wait_a_nxt;
  logic               wait_b_r;
  logic               wait_b_nxt;
  logic               car_green_nxt;
  logic               car_yellow_nxt;
  logic               car_red_nxt;
  logic               ped_walk_nxt;
  logic               ped_stop_nxt;
`ifdef CROSSING_FLASH_EN
  logic [TIMER_W-1:0] blink_cnt_r;
  logic [TIMER_W-1:0] blink_cnt_nxt;
  logic               blink_r;
  logic               blink_nxt;
`endif

  assign phase  = state_r;
  assign wait_a = wait_a_r;
  assign wait_b = wait_b_r;

  // Next-state, phase timer and request latching.
  always_comb begin
    state_nxt  = state_r;
    timer_nxt  = timer_r + TIMER_ONE;
    wait_a_nxt = wait_a_r | req_a;
    wait_b_nxt = wait_b_r | req_b;

    case (state_r)
      CAR_GREEN: begin
        // Compare with >= so a corrupted timer still saturates or exits.
        if ((wait_a_r | wait_b_r) && (timer_r >= MIN_GREEN_LAST)) begin
          state_nxt = CAR_YELLOW;
          timer_nxt = TIMER_ZERO;
        end else if (timer_r >= MIN_GREEN_LAST) begin
          timer_nxt = MIN_GREEN_LAST;
        end else begin
          timer_nxt = timer_r + TIMER_ONE;
        end
      end
      CAR_YELLOW: begin
        if (timer_r >= YELLOW_LAST) begin
          state_nxt = ALL_RED_PRE;
          timer_nxt = TIMER_ZERO;
        end else begin
          timer_nxt = timer_r + TIMER_ONE;
        end
      end
      ALL_RED_PRE: begin
        if (timer_r >= ALL_RED_LAST) begin
          // The walk serves every latched request, including one arriving now.
          state_nxt  = PED_WALK;
          timer_nxt  = TIMER_ZERO;
          wait_a_nxt = 1'b0;
          wait_b_nxt = 1'b0;
        end else begin
          timer_nxt = timer_r + TIMER_ONE;
        end
      end
      PED_WALK: begin
        // The crossing is already being served, so presses are dropped.
        wait_a_nxt = wait_a_r;
        wait_b_nxt = wait_b_r;
        if (timer_r >= WALK_LAST) begin
`ifdef CROSSING_FLASH_EN
          state_nxt = PED_FLASH;
`else
          state_nxt = ALL_RED_POST;
`endif
          timer_nxt = TIMER_ZERO;
        end else begin
          timer_nxt = timer_r + TIMER_ONE;
        end
      end
`ifdef CROSSING_FLASH_EN
      PED_FLASH: begin
        wait_a_nxt = wait_a_r;
        wait_b_nxt = wait_b_r;
        if (timer_r >= FLASH_LAST) begin
          state_nxt = ALL_RED_POST;
          timer_nxt = TIMER_ZERO;
        end else begin
          timer_nxt = timer_r + TIMER_ONE;
        end
      end
`endif
      ALL_RED_POST: begin
        if (timer_r >= ALL_RED_LAST) begin
          // Green restarts its minimum interval from zero.
          state_nxt = CAR_GREEN;
          timer_nxt = TIMER_ZERO;
        end else begin
          timer_nxt = timer_r + TIMER_ONE;
        end
      end
      default: begin
        // Illegal encoding: fall back to the safe default movement.
        state_nxt = CAR_GREEN;
        timer_nxt = TIMER_ZERO;
      end
    endcase
  end

`ifdef CROSSING_FLASH_EN
  // Walk-lamp blink generator, restarted high on every PED_FLASH entry.
  always_comb begin
    blink_cnt_nxt = blink_cnt_r;
    blink_nxt     = blink_r;
    if ((state_nxt == PED_FLASH) && (state_r != PED_FLASH)) begin
      blink_cnt_nxt = TIMER_ZERO;
      blink_nxt     = 1'b1;
    end else if (state_nxt == PED_FLASH) begin
      if (blink_cnt_r >= BLINK_LAST) begin
        blink_cnt_nxt = TIMER_ZERO;
        blink_nxt     = ~blink_r;
      end else begin
        blink_cnt_nxt = blink_cnt_r + TIMER_ONE;
        blink_nxt     = blink_r;
      end
    end else begin
      blink_cnt_nxt = TIMER_ZERO;
      blink_nxt     = 1'b0;
    end
  end
`endif

  // Lamp decode from the next state, so lamps switch on the same edge as it.
  always_comb begin
    car_green_nxt  = 1'b0;
    car_yellow_nxt = 1'b0;
    car_red_nxt    = 1'b0;
    ped_walk_nxt   = 1'b0;
    ped_stop_nxt   = 1'b1;
    case (state_nxt)
      CAR_GREEN:    car_green_nxt  = 1'b1;
      CAR_YELLOW:   car_yellow_nxt = 1'b1;
      ALL_RED_PRE:  car_red_nxt    = 1'b1;
      ALL_RED_POST: car_red_nxt    = 1'b1;
      PED_WALK: begin
        car_red_nxt  = 1'b1;
        ped_walk_nxt = 1'b1;
        ped_stop_nxt = 1'b0;
      end
`ifdef CROSSING_FLASH_EN
      PED_FLASH: begin
        car_red_nxt  = 1'b1;
        ped_walk_nxt = blink_nxt;
        ped_stop_nxt = 1'b0;
      end
`endif
      default: car_red_nxt = 1'b1;
    endcase
  end

  // State, timer, wait latches and lamp drivers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= CAR_GREEN;
      timer_r    <= TIMER_ZERO;
      wait_a_r   <= 1'b0;
      wait_b_r   <= 1'b0;
      car_green  <= 1'b1;
      car_yellow <= 1'b0;
      car_red    <= 1'b0;
      ped_walk   <= 1'b0;
      ped_stop   <= 1'b1;
    end else begin
      state_r    <= state_nxt;
      timer_r    <= timer_nxt;
      wait_a_r   <= wait_a_nxt;
      wait_b_r   <= wait_b_nxt;
      car_green  <= car_green_nxt;
      car_yellow <= car_yellow_nxt;
      car_red    <= car_red_nxt;
      ped_walk   <= ped_walk_nxt;
      ped_stop   <= ped_stop_nxt;
    end
  end

`ifdef CROSSING_FLASH_EN
  // Blink counter and phase bit for the flashing-walk lamp.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_r <= TIMER_ZERO;
      blink_r     <= 1'b0;
    end else begin
      blink_cnt_r <= blink_cnt_nxt;
      blink_r     <= blink_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_crossing_phase_controller.sv
// -----------------------------------------------------------------------------
// tb_crossing_phase_controller
//
// Self-checking bench for crossing_phase_controller with small timing
// parameters. Per-cycle vectors {inputs, expected phase/waits/blink} are
// queued and then applied in a loop. Reset corner cases are hand-written.
// Follows CROSSING_FLASH_EN like the design.
// -----------------------------------------------------------------------------
module tb_crossing_phase_controller;

  logic       clk;
  logic       rst;
  logic       req_a;
  logic       req_b;
  logic       car_green;
  logic       car_yellow;
  logic       car_red;
  logic       ped_walk;
  logic       ped_stop;
  logic       wait_a;
  logic       wait_b;
  logic [2:0] phase;

  int checks;
  int failures;

  typedef struct {
    logic       ra;
    logic       rb;
    logic [2:0] ph;
    logic       wa;
    logic       wb;
    logic       pw;   // expected ped_walk while in PED_FLASH
  } vec_t;

  vec_t tbl[$];

  crossing_phase_controller #(
    .MIN_GREEN    (8),
    .YELLOW_TIME  (3),
    .ALL_RED_TIME (2),
    .WALK_TIME    (5),
    .FLASH_TIME   (4),
    .FLASH_PERIOD (2),
    .TIMER_W      (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_a      (req_a),
    .req_b      (req_b),
    .car_green  (car_green),
    .car_yellow (car_yellow),
    .car_red    (car_red),
    .ped_walk   (ped_walk),
    .ped_stop   (ped_stop),
    .wait_a     (wait_a),
    .wait_b     (wait_b),
    .phase      (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lamp pattern the specification assigns to each phase.
  function automatic logic [9:0] expect_vec(input vec_t v);
    logic cg, cy, cr, pw, ps;
    cg = (v.ph == 3'd0);
    cy = (v.ph == 3'd1);
    cr = (v.ph >= 3'd2) && (v.ph <= 3'd5);
    pw = (v.ph == 3'd3) ? 1'b1 : ((v.ph == 3'd4) ? v.pw : 1'b0);
    ps = !((v.ph == 3'd3) || (v.ph == 3'd4));
    return {cg, cy, cr, pw, ps, v.wa, v.wb, v.ph};
  endfunction

  function automatic vec_t mk(input logic ra, input logic rb, input logic [2:0] ph,
                              input logic wa, input logic wb, input logic pw);
    vec_t v;
    v.ra = ra; v.rb = rb; v.ph = ph; v.wa = wa; v.wb = wb; v.pw = pw;
    return v;
  endfunction

  task automatic check(input string name, input logic [9:0] exp);
    logic [9:0] act;
    act = {car_green, car_yellow, car_red, ped_walk, ped_stop, wait_a, wait_b, phase};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got {cg,cy,cr,pw,ps,wa,wb,ph}=%b expected %b", name, act, exp);
    end
  endtask

  task automatic push(input logic ra, input logic rb, input logic [2:0] ph,
                      input logic wa, input logic wb, input logic pw, input int n);
    for (int i = 0; i < n; i++) tbl.push_back(mk(ra, rb, ph, wa, wb, pw));
  endtask

  // One complete walk cycle starting with the first yellow cycle.
  // p_walk / p_flash put presses inside walk/flash (must be ignored);
  // p_post presses in the second all-red-post cycle (must latch wait_a).
  task automatic add_walk_cycle(input logic wa, input logic wb, input logic p_walk,
                                input logic p_flash, input logic p_post);
    push(1'b0, 1'b0, 3'd1, wa, wb, 1'b0, 3);
    push(1'b0, 1'b0, 3'd2, wa, wb, 1'b0, 2);
    push(1'b0,   1'b0,   3'd3, 1'b0, 1'b0, 1'b0, 1);
    push(p_walk, 1'b0,   3'd3, 1'b0, 1'b0, 1'b0, 1);
    push(1'b0,   p_walk, 3'd3, 1'b0, 1'b0, 1'b0, 1);
    push(p_walk, p_walk, 3'd3, 1'b0, 1'b0, 1'b0, 1);
    push(1'b0,   1'b0,   3'd3, 1'b0, 1'b0, 1'b0, 1);
`ifdef CROSSING_FLASH_EN
    push(p_flash, p_flash, 3'd4, 1'b0, 1'b0, 1'b1, 1);
    push(p_flash, 1'b0,    3'd4, 1'b0, 1'b0, 1'b1, 1);
    push(1'b0,    p_flash, 3'd4, 1'b0, 1'b0, 1'b0, 1);
    push(p_flash, p_flash, 3'd4, 1'b0, 1'b0, 1'b0, 1);
`endif
    // First post cycle's input is sampled in the previous (walk/flash) state.
    push(p_post | p_flash, p_post | p_flash, 3'd5, 1'b0, 1'b0, 1'b0, 1);
    push(p_post, 1'b0, 3'd5, p_post, 1'b0, 1'b0, 1);
  endtask

  task automatic step_in(input logic ra, input logic rb);
    req_a = ra;
    req_b = rb;
    @(posedge clk);
    #1;
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      step_in(tbl[i].ra, tbl[i].rb);
      check($sformatf("%s[%0d]", tag, i), expect_vec(tbl[i]));
    end
    tbl.delete();
    req_a = 1'b0;
    req_b = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    rst   = 1'b1;
    req_a = 1'b0;
    req_b = 1'b0;
    @(posedge clk);
    #1;
    check(tag, expect_vec(mk(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0)));
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic       reached;
    logic [2:0] target;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    req_a    = 1'b0;
    req_b    = 1'b0;

    // Reset then 50 idle cycles: green, no waits.
    do_reset("reset_1");
    push(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 50);
    run_table("idle");

    // req_a with timer saturated: wait next cycle, yellow one cycle later.
    push(1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1);
    add_walk_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    push(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3);
    run_table("req_a_sat");

    // req_b at cycle 2 after reset: yellow only after timer reaches 7.
    do_reset("reset_2");
    push(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1);
    push(1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1);
    push(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 5);
    add_walk_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    push(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 10);
    // Simultaneous presses: both latch, one walk cycle, both clear together.
    push(1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 1);
    add_walk_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    push(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 10);
    // Presses during walk/flash ignored: green then holds indefinitely.
    push(1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1);
    add_walk_cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    push(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 30);
    // Press in all-red-post: latched, next walk after 8 further green cycles.
    push(1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1);
    add_walk_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    push(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 8);
    add_walk_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    push(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3);
    run_table("seq");

    // Asynchronous reset in the middle of the pedestrian phase.
    do_reset("reset_3");
`ifdef CROSSING_FLASH_EN
    target = 3'd4;
`else
    target = 3'd3;
`endif
    step_in(1'b1, 1'b0);
    reached = 1'b0;
    for (int i = 0; i < 60 && !reached; i++) begin
      step_in(1'b0, 1'b0);
      if (phase == target) reached = 1'b1;
    end
    checks++;
    if (!reached) begin
      failures++;
      $display("FAIL reach_ped_phase: phase=%0d expected %0d within 60 cycles", phase, target);
    end
    step_in(1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_ped", expect_vec(mk(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0)));
    @(negedge clk);
    rst = 1'b0;

    // Latched request is lost on asynchronous reset.
    step_in(1'b0, 1'b1);
    check("latch_b", expect_vec(mk(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0)));
    step_in(1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("rst_drops_wait", expect_vec(mk(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0)));
    @(negedge clk);
    rst = 1'b0;
    push(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 12);
    run_table("post_rst_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/crossing_phase_controller.md
Name: crossing_phase_controller

Overview:
- Sequences the pedestrian crossing: cars green by default, serves pedestrian requests with a timed walk cycle.
- Inputs are single-cycle press pulses from the per-side button debouncers (kerb A and kerb B).
- Outputs drive the car and pedestrian lamp drivers directly.
- Enforces a minimum car-green interval and all-red clearance phases between conflicting movements.

Parameters:
- MIN_GREEN, 500000000, minimum car-green duration in clk cycles (10 s at 50 MHz).
- YELLOW_TIME, 150000000, car-yellow duration in cycles.
- ALL_RED_TIME, 50000000, all-red clearance duration in cycles, used both before and after the walk phase.
- WALK_TIME, 350000000, steady pedestrian-walk duration in cycles.
- FLASH_TIME, 200000000, flashing-walk duration in cycles (used only with FLASH_EN).
- FLASH_PERIOD, 25000000, half-period of the walk lamp blink in cycles.
- TIMER_W, 32, phase timer width; must hold every duration above.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- req_a  in  1  debounced press pulse, kerb A
- req_b  in  1  debounced press pulse, kerb B
- car_green  out  1  car green lamp
- car_yellow  out  1  car yellow lamp
- car_red  out  1  car red lamp
- ped_walk  out  1  pedestrian walk lamp
- ped_stop  out  1  pedestrian don't-walk lamp
- wait_a  out  1  "wait" indicator, kerb A request latched
- wait_b  out  1  "wait" indicator, kerb B request latched
- phase  out  3  current state encoding, for debug

Behaviour:
- States and encodings: CAR_GREEN=0, CAR_YELLOW=1, ALL_RED_PRE=2, PED_WALK=3, PED_FLASH=4, ALL_RED_POST=5. Encodings 6 and 7 are unused and recover to CAR_GREEN on the next clock.
- Reset: state CAR_GREEN, timer 0, wait_a=wait_b=0, car_green=1, ped_stop=1, all other lamps 0, phase=0.
- All outputs are registered. Lamps change in the same clock edge as the state.
- Exactly one car lamp is high at a time. Exactly one of ped_walk/ped_stop is high, except during PED_FLASH blink-off, when both are 0.
- Phase timer:
  - Cleared to 0 on every state entry; increments each cycle.
  - In CAR_GREEN it saturates at MIN_GREEN-1.
  - A timed state of duration T lasts exactly T cycles.
- Request latching:
  - req_a sets wait_a and req_b sets wait_b on the next edge.
  - This applies in CAR_GREEN, CAR_YELLOW, ALL_RED_PRE and ALL_RED_POST.
  - Pulses during PED_WALK and PED_FLASH are ignored, because the crossing is already being served.
  - Simultaneous req_a and req_b latch both and are served by a single walk cycle.
  - Repeated pulses while latched have no effect.
- Transitions:
  - CAR_GREEN -> CAR_YELLOW when (wait_a | wait_b) and timer == MIN_GREEN-1. The evaluation uses registered wait bits, so a pulse in cycle k can at earliest cause the transition at edge k+2.
  - CAR_YELLOW -> ALL_RED_PRE after YELLOW_TIME cycles.
  - ALL_RED_PRE -> PED_WALK after ALL_RED_TIME cycles. Entering PED_WALK clears wait_a and wait_b on the same edge.
  - PED_WALK -> PED_FLASH after WALK_TIME cycles (FLASH_EN defined). Without FLASH_EN, PED_WALK -> ALL_RED_POST.
  - PED_FLASH -> ALL_RED_POST after FLASH_TIME cycles.
  - ALL_RED_POST -> CAR_GREEN after ALL_RED_TIME cycles. The timer restarts, so a request latched during ALL_RED_POST waits a full MIN_GREEN.
- Lamps per state:
  - CAR_GREEN: car_green, ped_stop.
  - CAR_YELLOW: car_yellow, ped_stop.
  - ALL_RED_PRE and ALL_RED_POST: car_red, ped_stop.
  - PED_WALK: car_red, ped_walk.
  - PED_FLASH: car_red; ped_walk toggles every FLASH_PERIOD cycles, starting high on entry; ped_stop=0.
- Reset mid-operation: immediate return to reset values from any state; latched requests are lost.

Optional Feature:
- Macro: CROSSING_FLASH_EN.
- Defined: the PED_FLASH state exists and behaves as above.
- Undefined: PED_FLASH is not built and FLASH_TIME/FLASH_PERIOD are unused. PED_WALK goes directly to ALL_RED_POST. Encoding 4 is then unused and recovers to CAR_GREEN.

Test Plan:
- Bench parameters for all scenarios: MIN_GREEN=8, YELLOW_TIME=3, ALL_RED_TIME=2, WALK_TIME=5, FLASH_TIME=4, FLASH_PERIOD=2.
- Reset, then 50 idle cycles -> stays CAR_GREEN with car_green=1, ped_stop=1, wait_a=wait_b=0 throughout.
- req_a pulse 20 cycles after reset (timer saturated) -> wait_a=1 next cycle; CAR_YELLOW one cycle later; yellow 3 cycles, red 2, walk 5, flash 4, all-red 2, then CAR_GREEN; wait_a clears on PED_WALK entry.
- req_b pulse at cycle 2 after reset -> yellow not entered before timer reaches 7 (cycle 8 of green); full sequence follows.
- req_a and req_b in the same cycle -> both wait lamps set; exactly one walk cycle; both clear together.
- Pulses during PED_WALK and PED_FLASH -> no wait set; CAR_GREEN holds indefinitely afterwards. A pulse during ALL_RED_POST -> wait set; the next walk starts only after 8 further green cycles.
- rst asserted mid-PED_FLASH -> outputs at reset values before the next clock edge.
- Check PED_FLASH blink pattern: ped_walk = 1,1,0,0.
- Build without CROSSING_FLASH_EN -> PED_WALK goes directly to ALL_RED_POST; phase is never 4.
